// File: rtl/strb_memory.sv
// Byte-strobed word memory with a post-reset clear sequence, range-checked
// accesses, selectable read/write collision policy and 1- or 2-cycle read latency.
module strb_memory #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 32,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   write_address,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    input  logic                    w_en,
    input  logic [ADDR_WIDTH-1:0]   read_address,
    input  logic                    out_en,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    read_err,
    output logic                    write_err,
    output logic                    init_busy
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] clr_cnt_reg, clr_cnt_next;

    logic             run_en;
    logic             clearing;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_accept;
    logic             rd_accept;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    logic             valid1_reg;
    logic             err1_reg;
    logic             write_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_INIT;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        if (state_reg == ST_INIT) begin
            clr_cnt_next = clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == LAST_IDX) begin
                state_next   = ST_RUN;
                clr_cnt_next = '0;
            end
        end
    end

    // Full-width compare so out-of-range addresses never alias onto real words.
    assign wr_in_range = {1'b0, write_address} < DEPTH_LIM;
    assign rd_in_range = {1'b0, read_address} < DEPTH_LIM;

    assign run_en    = (state_reg == ST_RUN) && !reset;
    assign clearing  = (state_reg == ST_INIT) && !reset;
    assign wr_accept = run_en && w_en && wr_in_range;
    assign rd_accept = run_en && out_en;
    assign wr_idx    = clearing ? clr_cnt_reg : write_address[IDX_W-1:0];
    assign rd_idx    = read_address[IDX_W-1:0];

    // One narrow RAM per byte lane keeps the byte enables a plain write enable.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] mem_lane [DEPTH];
        logic [7:0] rd_lane_reg;
        logic [7:0] wr_byte;
        logic       lane_we;
        logic       collide;

        assign wr_byte = clearing ? 8'h00 : write_data[8*gi +: 8];
        assign lane_we = clearing || (wr_accept && write_strb[gi]);
        assign collide = (WRITE_FIRST != 0) && lane_we && (wr_idx == rd_idx);

        always_ff @(posedge clk) begin
            if (lane_we) begin
                mem_lane[wr_idx] <= wr_byte;
            end
            if (reset) begin
                rd_lane_reg <= '0;
            end else if (rd_accept) begin
                if (!rd_in_range) begin
                    rd_lane_reg <= '0;
                end else if (collide) begin
                    rd_lane_reg <= wr_byte;
                end else begin
                    rd_lane_reg <= mem_lane[rd_idx];
                end
            end
        end

        assign rd_word[8*gi +: 8] = rd_lane_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid1_reg    <= 1'b0;
            err1_reg      <= 1'b0;
            write_err_reg <= 1'b0;
        end else begin
            valid1_reg    <= rd_accept;
            err1_reg      <= rd_accept && !rd_in_range;
            write_err_reg <= run_en && w_en && !wr_in_range;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  valid2_reg;
        logic                  err2_reg;
        logic [DATA_WIDTH-1:0] data2_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                valid2_reg <= 1'b0;
                err2_reg   <= 1'b0;
                data2_reg  <= '0;
            end else begin
                valid2_reg <= valid1_reg;
                err2_reg   <= err1_reg;
                if (valid1_reg) begin
                    data2_reg <= rd_word;
                end
            end
        end

        assign read_data  = data2_reg;
        assign read_valid = valid2_reg;
        assign read_err   = err2_reg;
    end else begin : g_lat1
        assign read_data  = rd_word;
        assign read_valid = valid1_reg;
        assign read_err   = err1_reg;
    end

    assign write_err = write_err_reg;
    assign init_busy = (state_reg == ST_INIT);

endmodule

// File: tb/tb_strb_memory.sv
// Directed bench for strb_memory: a latency-1 write-first instance and a
// latency-2 read-first instance share the same stimulus.
module tb_strb_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  write_address;
    logic [31:0] write_data;
    logic [3:0]  write_strb;
    logic        w_en;
    logic [5:0]  read_address;
    logic        out_en;

    logic [31:0] rd_data1, rd_data2;
    logic        rd_valid1, rd_valid2;
    logic        rd_err1, rd_err2;
    logic        wr_err1, wr_err2;
    logic        busy1, busy2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    strb_memory #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(32), .READ_LATENCY(1), .WRITE_FIRST(1)
    ) dut (
        .clk(clk), .reset(reset),
        .write_address(write_address), .write_data(write_data),
        .write_strb(write_strb), .w_en(w_en),
        .read_address(read_address), .out_en(out_en),
        .read_data(rd_data1), .read_valid(rd_valid1), .read_err(rd_err1),
        .write_err(wr_err1), .init_busy(busy1)
    );

    strb_memory #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .DEPTH(32), .READ_LATENCY(2), .WRITE_FIRST(0)
    ) dut_l2 (
        .clk(clk), .reset(reset),
        .write_address(write_address), .write_data(write_data),
        .write_strb(write_strb), .w_en(w_en),
        .read_address(read_address), .out_en(out_en),
        .read_data(rd_data2), .read_valid(rd_valid2), .read_err(rd_err2),
        .write_err(wr_err2), .init_busy(busy2)
    );

    // Outputs are sampled 1 time unit after the rising edge, then inputs change.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic werr, output logic werr_next);
        w_en = 1'b1; write_address = a; write_data = d; write_strb = s;
        cycle();
        w_en = 1'b0;
        werr = wr_err1;
        cycle();
        werr_next = wr_err1;
        $display("write addr=%0d data=%08h strb=%b write_err=%b", a, d, s, werr);
    endtask

    task automatic read_word(input logic [5:0] a,
                             output logic [31:0] d1, output logic v1, output logic e1,
                             output logic [31:0] d2, output logic v2, output logic e2,
                             output logic [31:0] d1h, output logic v1h, output logic e1h);
        out_en = 1'b1; read_address = a;
        cycle();
        out_en = 1'b0;
        d1 = rd_data1; v1 = rd_valid1; e1 = rd_err1;
        cycle();
        d2 = rd_data2; v2 = rd_valid2; e2 = rd_err2;
        d1h = rd_data1; v1h = rd_valid1; e1h = rd_err1;
        $display("read addr=%0d lat1=%08h/v%b/e%b lat2=%08h/v%b/e%b", a, d1, v1, e1, d2, v2, e2);
    endtask

    logic [31:0] r_d1, r_d2, r_d1h;
    logic        r_v1, r_e1, r_v2, r_e2, r_v1h, r_e1h;
    logic        w_e, w_en_next;

    task automatic test_reset();
        reset = 1'b1; w_en = 1'b1; out_en = 1'b1;
        write_address = 6'd40; read_address = 6'd1;
        write_data = 32'hFFFF_FFFF; write_strb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (rd_data1 !== 32'h0 || rd_valid1 !== 1'b0 || rd_err1 !== 1'b0 ||
                wr_err1 !== 1'b0 || busy1 !== 1'b1) begin
                fails++;
                $display("FAIL reset_lat1 cyc%0d: data=%08h valid=%b rerr=%b werr=%b busy=%b, required 0/0/0/0/1",
                         i, rd_data1, rd_valid1, rd_err1, wr_err1, busy1);
            end
            checks++;
            if (rd_data2 !== 32'h0 || rd_valid2 !== 1'b0 || rd_err2 !== 1'b0 ||
                wr_err2 !== 1'b0 || busy2 !== 1'b1) begin
                fails++;
                $display("FAIL reset_lat2 cyc%0d: data=%08h valid=%b rerr=%b werr=%b busy=%b, required 0/0/0/0/1",
                         i, rd_data2, rd_valid2, rd_err2, wr_err2, busy2);
            end
        end
    endtask

    // Releases reset, keeps requesting through INIT, and counts busy cycles.
    task automatic count_init(input string tag);
        int n;
        n = 0;
        reset = 1'b0;
        while (busy1 === 1'b1 && n < 100) begin
            checks++;
            if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0 || wr_err1 !== 1'b0 || rd_err1 !== 1'b0) begin
                fails++;
                $display("FAIL %s_ignored n=%0d: valid1=%b valid2=%b werr=%b rerr=%b, required all 0",
                         tag, n, rd_valid1, rd_valid2, wr_err1, rd_err1);
            end
            w_en = 1'b1; out_en = 1'b1;
            write_address = (n % 2 == 1) ? 6'd40 : 6'd7;
            write_data = 32'hFFFF_FFFF; write_strb = 4'hF;
            read_address = 6'(n % 32);
            n++;
            cycle();
        end
        w_en = 1'b0; out_en = 1'b0;
        checks++;
        if (n != 32) begin
            fails++;
            $display("FAIL %s_busy_len: init_busy high %0d cycles, required 32", tag, n);
        end
        checks++;
        if (rd_valid1 !== 1'b0 || wr_err1 !== 1'b0 || busy2 !== 1'b0) begin
            fails++;
            $display("FAIL %s_exit: valid1=%b werr=%b busy2=%b, required 0/0/0", tag, rd_valid1, wr_err1, busy2);
        end
        $display("init %s: busy cycles=%0d", tag, n);
    endtask

    task automatic test_clear_readback(input string tag);
        for (int i = 0; i < 32; i++) begin
            read_word(6'(i), r_d1, r_v1, r_e1, r_d2, r_v2, r_e2, r_d1h, r_v1h, r_e1h);
            checks++;
            if (r_v1 !== 1'b1 || r_d1 !== 32'h0 || r_e1 !== 1'b0 ||
                r_v2 !== 1'b1 || r_d2 !== 32'h0 || r_e2 !== 1'b0) begin
                fails++;
                $display("FAIL %s_zero addr=%0d: lat1=%08h/v%b/e%b lat2=%08h/v%b/e%b, required 00000000/v1/e0",
                         tag, i, r_d1, r_v1, r_e1, r_d2, r_v2, r_e2);
            end
        end
    endtask

    task automatic test_strobes();
        write_word(6'd3, 32'hDEAD_BEEF, 4'hF, w_e, w_en_next);
        write_word(6'd3, 32'h1122_3344, 4'b0101, w_e, w_en_next);
        write_word(6'd3, 32'hFFFF_FFFF, 4'b0000, w_e, w_en_next);
        checks++;
        if (w_e !== 1'b0) begin
            fails++;
            $display("FAIL strb_zero_err: write_err=%b, required 0", w_e);
        end
        read_word(6'd3, r_d1, r_v1, r_e1, r_d2, r_v2, r_e2, r_d1h, r_v1h, r_e1h);
        checks++;
        if (r_v1 !== 1'b1 || r_d1 !== 32'hDE22_BE44 || r_v2 !== 1'b1 || r_d2 !== 32'hDE22_BE44) begin
            fails++;
            $display("FAIL strb_merge: lat1=%08h/v%b lat2=%08h/v%b, required DE22BE44", r_d1, r_v1, r_d2, r_v2);
        end
        checks++;
        if (r_v1h !== 1'b0 || r_d1h !== 32'hDE22_BE44 || r_e1h !== 1'b0) begin
            fails++;
            $display("FAIL strb_hold: data=%08h valid=%b err=%b, required DE22BE44/0/0", r_d1h, r_v1h, r_e1h);
        end
    endtask

    task automatic test_range();
        write_word(6'd31, 32'h3131_3131, 4'hF, w_e, w_en_next);
        checks++;
        if (w_e !== 1'b0) begin
            fails++;
            $display("FAIL range_last_ok: write_err=%b, required 0", w_e);
        end
        write_word(6'd40, 32'hCAFE_F00D, 4'hF, w_e, w_en_next);
        checks++;
        if (w_e !== 1'b1 || w_en_next !== 1'b0) begin
            fails++;
            $display("FAIL range_werr_pulse: write_err=%b then %b, required 1 then 0", w_e, w_en_next);
        end
        write_word(6'd32, 32'h5555_5555, 4'hF, w_e, w_en_next);
        checks++;
        if (w_e !== 1'b1) begin
            fails++;
            $display("FAIL range_werr_32: write_err=%b, required 1", w_e);
        end
        read_word(6'd8, r_d1, r_v1, r_e1, r_d2, r_v2, r_e2, r_d1h, r_v1h, r_e1h);
        checks++;
        if (r_v1 !== 1'b1 || r_d1 !== 32'h0 || r_e1 !== 1'b0 || r_d2 !== 32'h0) begin
            fails++;
            $display("FAIL range_no_alias: addr8 lat1=%08h/v%b/e%b lat2=%08h, required 00000000/v1/e0",
                     r_d1, r_v1, r_e1, r_d2);
        end
        read_word(6'd0, r_d1, r_v1, r_e1, r_d2, r_v2, r_e2, r_d1h, r_v1h, r_e1h);
        checks++;
        if (r_d1 !== 32'h0 || r_d2 !== 32'h0) begin
            fails++;
            $display("FAIL range_no_alias0: addr0 lat1=%08h lat2=%08h, required 00000000", r_d1, r_d2);
        end
        read_word(6'd31, r_d1, r_v1, r_e1, r_d2, r_v2, r_e2, r_d1h, r_v1h, r_e1h);
        checks++;
        if (r_v1 !== 1'b1 || r_d1 !== 32'h3131_3131 || r_e1 !== 1'b0 || r_d2 !== 32'h3131_3131) begin
            fails++;
            $display("FAIL range_last_read: lat1=%08h/v%b/e%b lat2=%08h, required 31313131/v1/e0",
                     r_d1, r_v1, r_e1, r_d2);
        end
        read_word(6'd40, r_d1, r_v1, r_e1, r_d2, r_v2, r_e2, r_d1h, r_v1h, r_e1h);
        checks++;
        if (r_v1 !== 1'b1 || r_e1 !== 1'b1 || r_d1 !== 32'h0 ||
            r_v2 !== 1'b1 || r_e2 !== 1'b1 || r_d2 !== 32'h0) begin
            fails++;
            $display("FAIL range_rerr: lat1=%08h/v%b/e%b lat2=%08h/v%b/e%b, required 00000000/v1/e1",
                     r_d1, r_v1, r_e1, r_d2, r_v2, r_e2);
        end
        checks++;
        if (r_v1h !== 1'b0 || r_e1h !== 1'b0 || r_d1h !== 32'h0) begin
            fails++;
            $display("FAIL range_rerr_clear: data=%08h valid=%b err=%b, required 00000000/0/0", r_d1h, r_v1h, r_e1h);
        end
    endtask

    task automatic test_collision();
        write_word(6'd5, 32'hAAAA_AAAA, 4'hF, w_e, w_en_next);
        w_en = 1'b1; write_address = 6'd5; write_data = 32'h1234_5678; write_strb = 4'b0011;
        out_en = 1'b1; read_address = 6'd5;
        cycle();
        w_en = 1'b0; out_en = 1'b0;
        checks++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hAAAA_5678) begin
            fails++;
            $display("FAIL coll_write_first: data=%08h valid=%b, required AAAA5678/1", rd_data1, rd_valid1);
        end
        cycle();
        checks++;
        if (rd_valid2 !== 1'b1 || rd_data2 !== 32'hAAAA_AAAA) begin
            fails++;
            $display("FAIL coll_read_first: data=%08h valid=%b, required AAAAAAAA/1", rd_data2, rd_valid2);
        end
        $display("collision addr=5 lat1=%08h lat2=%08h", rd_data1, rd_data2);
        read_word(6'd5, r_d1, r_v1, r_e1, r_d2, r_v2, r_e2, r_d1h, r_v1h, r_e1h);
        checks++;
        if (r_d1 !== 32'hAAAA_5678 || r_d2 !== 32'hAAAA_5678) begin
            fails++;
            $display("FAIL coll_updated: lat1=%08h lat2=%08h, required AAAA5678", r_d1, r_d2);
        end
        // Write one address while reading another in the same cycle.
        w_en = 1'b1; write_address = 6'd6; write_data = 32'h6666_6666; write_strb = 4'hF;
        out_en = 1'b1; read_address = 6'd5;
        cycle();
        w_en = 1'b0; out_en = 1'b0;
        checks++;
        if (rd_data1 !== 32'hAAAA_5678) begin
            fails++;
            $display("FAIL indep_read: data=%08h, required AAAA5678", rd_data1);
        end
        cycle();
        read_word(6'd6, r_d1, r_v1, r_e1, r_d2, r_v2, r_e2, r_d1h, r_v1h, r_e1h);
        checks++;
        if (r_d1 !== 32'h6666_6666 || r_d2 !== 32'h6666_6666) begin
            fails++;
            $display("FAIL indep_write: lat1=%08h lat2=%08h, required 66666666", r_d1, r_d2);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int i = 0; i < 32; i++) begin
            write_word(6'(i), 32'h0101_0101 * 32'(i), 4'hF, w_e, w_en_next);
        end
        for (int c = 0; c < 34; c++) begin
            out_en = (c < 32); read_address = 6'(c % 32);
            cycle();
            checks++;
            if (c >= 1 && c <= 32) begin
                exp = 32'h0101_0101 * 32'(c - 1);
                if (rd_valid2 !== 1'b1 || rd_data2 !== exp || rd_err2 !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_lat2 c=%0d: data=%08h valid=%b, required %08h/1", c, rd_data2, rd_valid2, exp);
                end
            end else if (rd_valid2 !== 1'b0) begin
                fails++;
                $display("FAIL b2b_lat2_idle c=%0d: valid=%b, required 0", c, rd_valid2);
            end
            checks++;
            if (c < 32) begin
                exp = 32'h0101_0101 * 32'(c);
                if (rd_valid1 !== 1'b1 || rd_data1 !== exp) begin
                    fails++;
                    $display("FAIL b2b_lat1 c=%0d: data=%08h valid=%b, required %08h/1", c, rd_data1, rd_valid1, exp);
                end
            end else if (rd_valid1 !== 1'b0) begin
                fails++;
                $display("FAIL b2b_lat1_idle c=%0d: valid=%b, required 0", c, rd_valid1);
            end
        end
        out_en = 1'b0;
        $display("burst of 32 reads complete");
    endtask

    task automatic test_reset_mid_op();
        for (int c = 0; c < 4; c++) begin
            out_en = 1'b1; read_address = 6'(c + 2);
            cycle();
        end
        reset = 1'b1;
        cycle();
        out_en = 1'b0;
        checks++;
        if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0 || rd_data1 !== 32'h0 ||
            rd_data2 !== 32'h0 || busy1 !== 1'b1) begin
            fails++;
            $display("FAIL midop_flush: valid1=%b valid2=%b data1=%08h data2=%08h busy=%b, required 0/0/0/0/1",
                     rd_valid1, rd_valid2, rd_data1, rd_data2, busy1);
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            checks++;
            if (rd_valid2 !== 1'b0 || busy1 !== 1'b1) begin
                fails++;
                $display("FAIL midop_init c=%0d: valid2=%b busy=%b, required 0/1", c, rd_valid2, busy1);
            end
        end
        reset = 1'b1;
        cycle();
        count_init("reinit");
        test_clear_readback("reinit");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        count_init("init");
        test_clear_readback("clear");
        test_strobes();
        test_range();
        test_collision();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/strb_memory.md
Name: strb_memory

Overview:
Parametrised successor of the simple dual-address register-file memory. Adds AXI-lite style byte write strobes, a configurable read latency with a read-valid qualifier, and address range checking with error flags. Also adds a hardware clear sequence after reset and a selectable read/write collision policy. Sits behind the AXI4-Lite slave as its backing store and supplies the write-strobe and error semantics that the slave response logic needs.

Parameters:
ADDR_WIDTH, 6, address bus width; may exceed clog2(DEPTH).
DATA_WIDTH, 32, word width; must be a multiple of 8.
DEPTH, 32, number of words; valid addresses are 0..DEPTH-1.
READ_LATENCY, 1, cycles from sampled out_en to read_valid; legal values 1 or 2.
WRITE_FIRST, 1, collision policy: 1 = read returns newly written bytes; 0 = read returns old data.

Ports:
clk  in  1  clock; all logic is on its rising edge.
reset  in  1  synchronous, active-high reset.
write_address  in  ADDR_WIDTH  write word address.
write_data  in  DATA_WIDTH  write data.
write_strb  in  DATA_WIDTH/8  byte enables; bit i selects byte lane [8i+7:8i].
w_en  in  1  write request, sampled each edge.
read_address  in  ADDR_WIDTH  read word address.
out_en  in  1  read request, sampled each edge.
read_data  out  DATA_WIDTH  read result; meaningful only while read_valid=1.
read_valid  out  1  one-cycle pulse per accepted read.
read_err  out  1  asserted with read_valid when the read address was >= DEPTH.
write_err  out  1  one-cycle pulse, the cycle after an out-of-range write is sampled.
init_busy  out  1  high while the clear sequence runs; requests are ignored.

Behaviour:
- Reset (reset=1 at an edge):
  - Outputs after that edge: read_data=0, read_valid=0, read_err=0, write_err=0, init_busy=1.
  - The read pipeline is flushed; any in-flight read never produces read_valid.
- State machine INIT -> RUN:
  - INIT is entered on reset. A clear counter walks addresses 0..DEPTH-1, writing zero to one word per cycle.
  - INIT lasts exactly DEPTH cycles after reset deasserts, then the block moves to RUN and init_busy drops to 0.
  - In INIT, w_en and out_en are ignored: no write, no read_valid, no error pulses.
  - Reset asserted in any state, including mid-INIT, restarts INIT from address 0.
- Write (RUN):
  - w_en=1 with write_address<DEPTH updates, at that edge, only the byte lanes with write_strb bit set.
  - write_strb=0 is a legal no-op and raises no error.
  - If write_address>=DEPTH: no array update, no aliasing (upper bits are not truncated), write_err=1 for exactly the next cycle.
- Read (RUN):
  - out_en=1 sampled at edge k gives read_valid=1 for the single cycle after edge k+READ_LATENCY-1.
  - Reads may be issued every cycle; throughput is one per cycle at either latency.
  - Out-of-range read: read_data=0 and read_err=1 in the same cycle as read_valid.
  - When read_valid=0, read_data holds its last value and read_err=0.
- Collision (same cycle, same in-range address, w_en=1 and out_en=1):
  - WRITE_FIRST=1: returned word = strobed new bytes merged with old bytes.
  - WRITE_FIRST=0: returned word = pre-write contents.
  - The array is updated under both settings.
- Simultaneous write and read to different addresses are independent.
- Error flags never assert outside the cases above.

Test Plan:
(All cases use defaults ADDR_WIDTH=6, DATA_WIDTH=32, DEPTH=32, READ_LATENCY=1 unless stated.)
1. Clear: hold reset 3 cycles, release -> init_busy=1 for 32 cycles then 0; reads of 0..31 all return 0x00000000 with read_err=0.
2. Strobes: write addr 3 = 0xDEADBEEF strb 4'hF, then 0x11223344 strb 4'b0101 -> read addr 3 returns 0xDE22BE44.
3. Range: write addr 40 = 0xCAFEF00D -> write_err pulses one cycle; addr 8 still reads 0; read addr 40 -> read_valid=1, read_err=1, read_data=0.
4. Collision: mem[5]=0xAAAAAAAA; same cycle write 5 = 0x12345678 strb 4'b0011 and read 5 -> 0xAAAA5678 (WRITE_FIRST=1) or 0xAAAAAAAA (WRITE_FIRST=0); later read of 5 returns 0xAAAA5678 under both settings.
5. Pipelined reads (READ_LATENCY=2): out_en held high 32 cycles over addrs 0..31 holding i*0x01010101 -> first read_valid 2 cycles after first sample, 32 consecutive valid cycles, data in order.
6. Reset mid-operation: assert reset during a read burst and again mid-INIT -> no read_valid after reset, INIT restarts at 0, init_busy=1 for 32 cycles after final release, all words read back 0.
